// File: rtl/ins_queue_dual.sv
// ins_queue_dual: in-order (instruction, PC) buffer between fetch and decode.
// One push and up to two pops per cycle. The two oldest entries are presented
// show-ahead for dual decode. A sticky overflow flag records dropped pushes.
module ins_queue_dual #(
  parameter int INS_W        = 32,
  parameter int PC_W         = 32,
  parameter int DEPTH        = 16,
  parameter int AFULL_MARGIN = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ready,
  input  logic             clear,
  input  logic             push,
  input  logic [INS_W-1:0] push_ins,
  input  logic [PC_W-1:0]  push_pc,
  input  logic [1:0]       pop_n,
  output logic             full,
  output logic             almost_full,
  output logic [$clog2(DEPTH):0] count,
  output logic             valid0,
  output logic [INS_W-1:0] ins0,
  output logic [PC_W-1:0]  pc0,
  output logic             valid1,
  output logic [INS_W-1:0] ins1,
  output logic [PC_W-1:0]  pc1,
  output logic             ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] AFULL_C = (AW+1)'(DEPTH - AFULL_MARGIN);

  logic [INS_W-1:0] ins_mem_q [DEPTH];
  logic [PC_W-1:0]  pc_mem_q  [DEPTH];

  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [AW:0]   count_q, count_d;
  logic          ovf_q, ovf_d;

  logic [AW:0]   pop_req_s;
  logic [AW:0]   pop_eff_s;
  logic          push_acc_s;
  logic          mem_we_s;
  logic [AW-1:0] head1_s;

  // Clamp the pop request to 2, truncate it to occupancy, and decide whether the push fits.
  always_comb begin
    pop_req_s = {(AW+1){1'b0}};
    case (pop_n)
      2'd0:    pop_req_s = {(AW+1){1'b0}};
      2'd1:    pop_req_s = {{AW{1'b0}}, 1'b1};
      default: pop_req_s = {{(AW-1){1'b0}}, 2'd2};
    endcase
    if (pop_req_s > count_q) begin
      pop_eff_s = count_q;
    end else begin
      pop_eff_s = pop_req_s;
    end
    // Pops retire before the push is judged, so a full queue can accept while draining.
    push_acc_s = push && ((count_q - pop_eff_s) < DEPTH_C);
    mem_we_s   = push_acc_s && ready && !reset && !clear;
  end

  // Next-state for pointers, occupancy and overflow; reset and clear flush, ready=0 holds.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (reset || clear) begin
      head_d  = {AW{1'b0}};
      tail_d  = {AW{1'b0}};
      count_d = {(AW+1){1'b0}};
      ovf_d   = 1'b0;
    end else if (ready) begin
      head_d  = head_q + AW'(pop_eff_s);
      count_d = count_q - pop_eff_s + {{AW{1'b0}}, push_acc_s};
      if (push_acc_s) begin
        tail_d = tail_q + {{(AW-1){1'b0}}, 1'b1};
      end else if (push) begin
        ovf_d = 1'b1;
      end else begin
        ovf_d = ovf_q;
      end
    end else begin
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q;
      ovf_d   = ovf_q;
    end
  end

  // Control state register.
  always_ff @(posedge clk) begin
    head_q  <= head_d;
    tail_q  <= tail_d;
    count_q <= count_d;
    ovf_q   <= ovf_d;
  end

  // Entry storage; contents are never flushed, only the pointers are.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      ins_mem_q[tail_q] <= push_ins;
      pc_mem_q[tail_q]  <= push_pc;
    end
  end

  // Show-ahead front outputs, zeroed when the slot is not occupied.
  always_comb begin
    head1_s     = head_q + {{(AW-1){1'b0}}, 1'b1};
    count       = count_q;
    full        = (count_q == DEPTH_C);
    almost_full = (count_q >= AFULL_C);
    valid0      = (count_q >= {{AW{1'b0}}, 1'b1});
    valid1      = (count_q >= {{(AW-1){1'b0}}, 2'd2});
    ovf         = ovf_q;
    if (valid0) begin
      ins0 = ins_mem_q[head_q];
      pc0  = pc_mem_q[head_q];
    end else begin
      ins0 = {INS_W{1'b0}};
      pc0  = {PC_W{1'b0}};
    end
    if (valid1) begin
      ins1 = ins_mem_q[head1_s];
      pc1  = pc_mem_q[head1_s];
    end else begin
      ins1 = {INS_W{1'b0}};
      pc1  = {PC_W{1'b0}};
    end
  end

endmodule

// File: tb/tb_ins_queue_dual.sv
// Testbench for ins_queue_dual: directed scenarios plus a random stream, all
// checked every cycle against a queue-based reference model.
module tb_ins_queue_dual;

  localparam int INS_W = 32;
  localparam int PC_W  = 32;
  localparam int DEPTH = 16;
  localparam int AFM   = 2;

  logic             clk = 1'b0;
  logic             reset, ready, clear, push;
  logic [INS_W-1:0] push_ins;
  logic [PC_W-1:0]  push_pc;
  logic [1:0]       pop_n;
  logic             full, almost_full, valid0, valid1, ovf;
  logic [4:0]       count;
  logic [INS_W-1:0] ins0, ins1;
  logic [PC_W-1:0]  pc0, pc1;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: plain queue of {ins, pc} plus the sticky overflow bit.
  logic [INS_W+PC_W-1:0] mq[$];
  logic                  movf = 1'b0;

  ins_queue_dual #(.INS_W(INS_W), .PC_W(PC_W), .DEPTH(DEPTH), .AFULL_MARGIN(AFM)) dut (
    .clk(clk), .reset(reset), .ready(ready), .clear(clear), .push(push),
    .push_ins(push_ins), .push_pc(push_pc), .pop_n(pop_n),
    .full(full), .almost_full(almost_full), .count(count),
    .valid0(valid0), .ins0(ins0), .pc0(pc0),
    .valid1(valid1), .ins1(ins1), .pc1(pc1), .ovf(ovf)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input logic r, input logic c, input logic rdy, input logic p,
                            input logic [1:0] pn, input logic [INS_W-1:0] pi,
                            input logic [PC_W-1:0] pp);
    int n;
    if (r || c) begin
      mq.delete();
      movf = 1'b0;
    end else if (rdy) begin
      n = (pn > 2'd2) ? 2 : int'(pn);
      if (n > mq.size()) n = mq.size();
      for (int k = 0; k < n; k++) void'(mq.pop_front());
      if (p) begin
        if (mq.size() < DEPTH) mq.push_back({pi, pp});
        else movf = 1'b1;
      end
    end
  endtask

  task automatic compare_all();
    logic [INS_W+PC_W-1:0] e0, e1;
    e0 = (mq.size() >= 1) ? mq[0] : '0;
    e1 = (mq.size() >= 2) ? mq[1] : '0;
    check_eq("count", 64'(count), 64'(mq.size()));
    check_eq("full", 64'(full), 64'(mq.size() == DEPTH));
    check_eq("almost_full", 64'(almost_full), 64'(mq.size() >= DEPTH - AFM));
    check_eq("valid0", 64'(valid0), 64'(mq.size() >= 1));
    check_eq("valid1", 64'(valid1), 64'(mq.size() >= 2));
    check_eq("ins0", 64'(ins0), 64'(e0[INS_W+PC_W-1:PC_W]));
    check_eq("pc0", 64'(pc0), 64'(e0[PC_W-1:0]));
    check_eq("ins1", 64'(ins1), 64'(e1[INS_W+PC_W-1:PC_W]));
    check_eq("pc1", 64'(pc1), 64'(e1[PC_W-1:0]));
    check_eq("ovf", 64'(ovf), 64'(movf));
  endtask

  // Apply one cycle of stimulus, advance the model at the edge, compare after it.
  task automatic cyc(input logic r, input logic c, input logic rdy, input logic p,
                     input logic [1:0] pn, input logic [INS_W-1:0] pi,
                     input logic [PC_W-1:0] pp);
    reset = r; clear = c; ready = rdy; push = p; pop_n = pn; push_ins = pi; push_pc = pp;
    @(posedge clk);
    model_step(r, c, rdy, p, pn, pi, pp);
    #1;
    compare_all();
  endtask

  initial begin
    logic [4:0] cnt_hold;
    logic [INS_W-1:0] ins0_hold;
    int ph;
    reset = 1'b1; clear = 1'b0; ready = 1'b1; push = 1'b0; pop_n = 2'd0;
    push_ins = '0; push_pc = '0;

    // Reset state.
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 32'd0, 32'd0);
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 2'd2, 32'h55, 32'h66);
    check_eq("rst_count", 64'(count), 64'd0);
    check_eq("rst_valid0", 64'(valid0), 64'd0);

    // Five pushes, no pops.
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 32'h100 + i, 32'(4 * i));
    check_eq("five_count", 64'(count), 64'd5);
    check_eq("five_ins0", 64'(ins0), 64'h100);
    check_eq("five_ins1", 64'(ins1), 64'h101);
    check_eq("five_afull", 64'(almost_full), 64'd0);

    // Fill to full, then overflow once.
    for (int i = 5; i < 16; i++) cyc(1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 32'h100 + i, 32'(4 * i));
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 32'hDEAD, 32'hBEEF);
    check_eq("ovf_full", 64'(full), 64'd1);
    check_eq("ovf_flag", 64'(ovf), 64'd1);
    check_eq("ovf_count", 64'(count), 64'd16);

    // Drain by twos; order is checked against the model each cycle.
    for (int i = 0; i < 8; i++) begin
      check_eq("drain_ins0", 64'(ins0), 64'(32'h100 + 2 * i));
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 32'd0, 32'd0);
    end
    check_eq("drain_count", 64'(count), 64'd0);

    // Refill after clear, then push into a full queue while popping one.
    cyc(1'b0, 1'b1, 1'b1, 1'b0, 2'd0, 32'd0, 32'd0);
    for (int i = 0; i < 16; i++) cyc(1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 32'h200 + i, 32'(i));
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 2'd1, 32'h2FF, 32'hFF);
    check_eq("fullpush_count", 64'(count), 64'd16);
    check_eq("fullpush_ovf", 64'(ovf), 64'd0);
    for (int i = 0; i < 15; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 32'd0, 32'd0);
    check_eq("fullpush_last", 64'(ins0), 64'h2FF);
    check_eq("fullpush_one", 64'(count), 64'd1);

    // count=1 with pop_n=2, then pop from empty.
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 32'd0, 32'd0);
    check_eq("pop2_one_count", 64'(count), 64'd0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 32'd0, 32'd0);
    check_eq("pop_empty_valid0", 64'(valid0), 64'd0);

    // Count=1, push with pop_n=3: pop truncated to 1, push accepted.
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 32'h300, 32'h30);
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 2'd3, 32'h301, 32'h31);
    check_eq("swap_count", 64'(count), 64'd1);
    check_eq("swap_ins0", 64'(ins0), 64'h301);

    // Freeze with ready=0 while toggling push and pop.
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, 1'b1, 2'd0, 32'h400 + i, 32'h40 + i);
    cnt_hold = count; ins0_hold = ins0;
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, i[0], 2'd2, 32'h500, 32'h50);
    check_eq("hold_count", 64'(count), 64'(cnt_hold));
    check_eq("hold_ins0", 64'(ins0), 64'(ins0_hold));
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 32'h600, 32'h60);
    check_eq("clear_count", 64'(count), 64'd0);
    check_eq("clear_valid0", 64'(valid0), 64'd0);

    // Random stream with phases that push hard or drain hard, plus mid-stream resets.
    for (int i = 0; i < 2000; i++) begin
      ph = (i / 200) % 2;
      cyc((i == 1000) || ($urandom_range(0, 199) == 0),
          ($urandom_range(0, 99) < 2),
          ($urandom_range(0, 9) != 0),
          (ph == 1) ? ($urandom_range(0, 99) < 90) : ($urandom_range(0, 99) < 45),
          (ph == 1) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(0, 3)),
          $urandom, $urandom);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
